rx_deserializer: RTL and testbench

- Downstream consumer of the programmable bit-period counter: takes that counter's one-cycle rollover strobe as `shift_strobe` and samples the serial line on each strobe.
- Assembles NUM_BITS-wide words and presents each in an output holding register with a valid/ready handshake.
- Flags overrun when a new word completes before the previous word is accepted.
- Sits between the bit-timing counter and the packet/FIFO logic.

---
 rtl/rx_deserializer.sv | 153 +++++++++++++++
 tb/tb_rx_deserializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deserializer.sv
// rtl/rx_deserializer.sv - serial-to-parallel word assembler with valid/ready holding register
// Optional feature macro: RX_DESER_PARITY_EN (adds an even-parity bit after the data bits)
module rx_deserializer #(
  parameter int NUM_BITS  = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_strobe,
  input  logic                serial_in,
  input  logic                frame_start,
  input  logic                data_ready,
  input  logic                clear_error,
  output logic [NUM_BITS-1:0] data_out,
  output logic                data_valid,
  output logic                overrun_error,
  output logic                parity_error
);

  localparam int            CW       = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BITS - 1);

`ifdef RX_DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] r_data;
  logic                r_valid;
  logic                r_ovr;
  logic [NUM_BITS-1:0] w_shift_next;
  logic                w_done;
  logic                w_load;
  logic                w_drop;

`ifdef RX_DESER_PARITY_EN
  logic r_par;
  logic r_perr;
  logic w_perr;
  // Even parity over data plus received parity bit: 1 means the word is corrupt.
  assign w_perr = (^r_shift) ^ r_par;
`endif

  // Shift direction decides which end of the word the first received bit lands in.
  assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[NUM_BITS-2:0], serial_in}
                                         : {serial_in, r_shift[NUM_BITS-1:1]};

  // A completed word is transferred on the DONE edge unless the old word is still unaccepted.
  assign w_done = (r_state == DONE);
  assign w_load = w_done && (!r_valid || data_ready);
  assign w_drop = w_done && r_valid && !data_ready;

  // Bit-assembly FSM: frame_start realigns and wins over a coincident strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
`ifdef RX_DESER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (frame_start) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (shift_strobe) begin
            r_shift <= w_shift_next;
            r_cnt   <= CW'(1);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_strobe) begin
            r_shift <= w_shift_next;
            if (r_cnt == LAST_IDX) begin
              r_cnt   <= '0;
`ifdef RX_DESER_PARITY_EN
              r_state <= PAR;
`else
              r_state <= DONE;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
`ifdef RX_DESER_PARITY_EN
        PAR: begin
          if (shift_strobe) begin
            r_par   <= serial_in;
            r_state <= DONE;
          end
        end
`endif
        DONE: begin
          // The holding register takes the pre-edge shift value, so this strobe is safe to shift.
          if (shift_strobe) begin
            r_shift <= w_shift_next;
            r_cnt   <= CW'(1);
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Holding register, valid/ready handshake and sticky overrun flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef RX_DESER_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
`ifdef RX_DESER_PARITY_EN
        r_perr  <= w_perr;
`endif
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (clear_error) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign data_out      = r_data;
  assign data_valid    = r_valid;
  assign overrun_error = r_ovr;
`ifdef RX_DESER_PARITY_EN
  assign parity_error  = r_perr;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_deserializer.sv
// tb/tb_rx_deserializer.sv - scoreboard bench for rx_deserializer (MSB-first and LSB-first instances)
module tb_rx_deserializer;

`ifdef RX_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       shift_strobe = 1'b0;
  logic       serial_in = 1'b0;
  logic       frame_start = 1'b0;
  logic       clear_error = 1'b0;
  logic       dir_ready = 1'b0;
  logic       mon_ready = 1'b0;
  logic       mon_en = 1'b0;
  logic       data_ready;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid, m_ovr, l_ovr, m_perr, l_perr;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] m;
    logic [7:0] l;
    logic       p;
  } exp_t;
  exp_t q[$];

  assign data_ready = mon_en ? mon_ready : dir_ready;

  always #5 clk = ~clk;

  rx_deserializer #(.NUM_BITS(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .n_rst(n_rst), .shift_strobe(shift_strobe), .serial_in(serial_in),
    .frame_start(frame_start), .data_ready(data_ready), .clear_error(clear_error),
    .data_out(m_data), .data_valid(m_valid), .overrun_error(m_ovr), .parity_error(m_perr)
  );

  rx_deserializer #(.NUM_BITS(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .n_rst(n_rst), .shift_strobe(shift_strobe), .serial_in(serial_in),
    .frame_start(frame_start), .data_ready(data_ready), .clear_error(clear_error),
    .data_out(l_data), .data_valid(l_valid), .overrun_error(l_ovr), .parity_error(l_perr)
  );

  // Bits are sent in the order w[7], w[6], ... w[0]; an LSB-first receiver sees them mirrored.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic exp_par(input logic [7:0] w, input logic p);
    return PAR_EN ? ((^w) ^ p) : 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe_bit(input logic b, input int gap);
    shift_strobe = 1'b1;
    serial_in    = b;
    @(negedge clk);
    shift_strobe = 1'b0;
    serial_in    = 1'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  // Sends bits first..7 of w (then the parity bit when enabled); returns in the DONE cycle.
  task automatic send_bits(input logic [7:0] w, input int first, input logic p, input int gap);
    for (int i = first; i < 8; i++) begin
      strobe_bit(w[7-i], (!PAR_EN && i == 7) ? 1 : gap);
    end
    if (PAR_EN) strobe_bit(p, 1);
  endtask

  task automatic check_word(input string name, input logic [7:0] w, input logic p);
    chk({name, "_valid"}, {31'd0, m_valid}, 32'd1);
    chk({name, "_msb"}, {24'd0, m_data}, {24'd0, w});
    chk({name, "_lsb"}, {24'd0, l_data}, {24'd0, rev8(w)});
    chk({name, "_par"}, {31'd0, m_perr}, {31'd0, exp_par(w, p)});
  endtask

  task automatic accept();
    dir_ready = 1'b1;
    @(negedge clk);
    dir_ready = 1'b0;
  endtask

  // Scoreboard monitor: drives random ready and checks every accepted word against the queue.
  int vcnt = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      vcnt      = m_valid ? vcnt + 1 : 0;
      mon_ready = (vcnt >= 3) ? 1'b1 : 1'($urandom % 2);
      if (m_valid && mon_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got word %0h expected none", m_data);
        end else begin
          e = q.pop_front();
          chk("sb_msb", {24'd0, m_data}, {24'd0, e.m});
          chk("sb_lsb", {24'd0, l_data}, {24'd0, e.l});
          chk("sb_lvalid", {31'd0, l_valid}, 32'd1);
          chk("sb_par_m", {31'd0, m_perr}, {31'd0, e.p});
          chk("sb_par_l", {31'd0, l_perr}, {31'd0, e.p});
        end
        vcnt = 0;
      end
    end
  end

  initial begin
    int cnt;
    logic [7:0] w;
    logic p;
    exp_t e;

    repeat (2) @(negedge clk);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_ovr", {31'd0, m_ovr}, 32'd0);
    chk("rst_par", {31'd0, m_perr}, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // A5, strobes every 4 cycles, exact latency and handshake drop
    send_bits(8'hA5, 0, 1'b0, 4);
    chk("lat_early", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    check_word("a5p0", 8'hA5, 1'b0);
    accept();
    chk("hs_drop", {31'd0, m_valid}, 32'd0);

    // Same word with parity bit 1: delivered either way
    send_bits(8'hA5, 0, 1'b1, 4);
    @(negedge clk);
    check_word("a5p1", 8'hA5, 1'b1);
    accept();

    // Bits 1,1,0,0,0,0,0,0: LSB-first instance reads 03
    send_bits(8'hC0, 0, 1'b0, 2);
    @(negedge clk);
    chk("lsb03", {24'd0, l_data}, 32'h03);
    check_word("c0", 8'hC0, 1'b0);
    accept();

    // Overrun: 11 held, 22 dropped
    send_bits(8'h11, 0, 1'b0, 1);
    @(negedge clk);
    check_word("w11", 8'h11, 1'b0);
    send_bits(8'h22, 0, 1'b0, 1);
    @(negedge clk);
    check_word("ovr_keep", 8'h11, 1'b0);
    chk("ovr_set", {31'd0, m_ovr}, 32'd1);
    chk("ovr_set_l", {31'd0, l_ovr}, 32'd1);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    chk("ovr_clr", {31'd0, m_ovr}, 32'd0);

    // Clear and a new overrun in the same cycle: overrun wins
    send_bits(8'h22, 0, 1'b0, 1);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    chk("ovr_wins", {31'd0, m_ovr}, 32'd1);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    chk("ovr_clr2", {31'd0, m_ovr}, 32'd0);

    // Ready on the DONE cycle of 22, plus a strobe that becomes bit 0 of 6B
    send_bits(8'h22, 0, 1'b0, 1);
    w            = 8'h6B;
    dir_ready    = 1'b1;
    shift_strobe = 1'b1;
    serial_in    = w[7];
    @(negedge clk);
    dir_ready    = 1'b0;
    shift_strobe = 1'b0;
    check_word("done_rdy", 8'h22, 1'b0);
    chk("done_rdy_ovr", {31'd0, m_ovr}, 32'd0);
    accept();
    chk("done_rdy_drop", {31'd0, m_valid}, 32'd0);
    send_bits(w, 1, 1'b1, 2);
    @(negedge clk);
    check_word("w6b", w, 1'b1);
    accept();

    // Three bits, then frame_start with a strobe, then 3C
    repeat (3) strobe_bit(1'b1, 2);
    frame_start  = 1'b1;
    shift_strobe = 1'b1;
    serial_in    = 1'b1;
    @(negedge clk);
    frame_start  = 1'b0;
    shift_strobe = 1'b0;
    send_bits(8'h3C, 0, 1'b0, 3);
    @(negedge clk);
    check_word("fs3c", 8'h3C, 1'b0);

    // 3C still held; reset after 5 bits clears outputs at once
    repeat (5) strobe_bit(1'b1, 2);
    n_rst = 1'b0;
    #1;
    chk("arst_data", {24'd0, m_data}, 32'd0);
    chk("arst_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    send_bits(8'h96, 0, 1'b1, 2);
    @(negedge clk);
    check_word("post_rst", 8'h96, 1'b1);
    accept();
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (m_valid) cnt++;
    end
    chk("one_word", cnt, 32'd0);

    // Randomized words with random strobe spacing and random ready
    mon_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w   = 8'($urandom);
      p   = 1'($urandom);
      e.m = w;
      e.l = rev8(w);
      e.p = exp_par(w, p);
      q.push_back(e);
      send_bits(w, 0, p, int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    cnt = 0;
    while ((q.size() != 0 || m_valid) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("sb_drain", q.size(), 32'd0);
    chk("rand_ovr_m", {31'd0, m_ovr}, 32'd0);
    chk("rand_ovr_l", {31'd0, l_ovr}, 32'd0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
